calc_core: RTL and testbench
============================

# calc_core

Parametrised calculator core that consumes decoded keypad events and produces the BCD word for the display driver. It sits between the keypad decoder (`num_val`/`op_val`/`is_*` strobes) and the 7-segment multiplexer. It succeeds the fixed 4-digit pass-through stage and adds the following:

- configurable digit count
- operand entry with digit shifting
- add, subtract and multiply
- result chaining
- error reporting
- a sequential binary-to-BCD converter (double-dabble)

## Interface
Parameters:
- DIGITS, 4, number of BCD display digits / max operand digits
- BIN_W, 14, binary operand width; must satisfy 2^BIN_W > 10^DIGITS − 1

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- num_val  in  4  digit 0–9, valid when is_num; values 10–15 ignored
- op_val  in  2  00 add, 01 sub, 10 mul, 11 clear-all; valid when is_op
- is_num  in  1  single-cycle digit strobe
- is_op  in  1  single-cycle operator strobe
- is_eq  in  1  single-cycle equals strobe
- data_out_bcd  out  4*DIGITS  display word, digit 0 in bits [3:0]
- busy  out  1  high while computing/converting; all strobes ignored
- err  out  1  high in ERR state

## Operation
- **Strobe priority (same cycle):** is_num > is_op > is_eq; lower-priority strobes in that cycle are dropped.
- **Internal state:**
  - A, B: binary, BIN_W bits.
  - Per-operand BCD shadow.
  - Digit count 0..DIGITS.
  - Pending op (2 bits).
  - Result register: 2*BIN_W bits.
- **ENTER_A** (reset state)
  - Digit: if count < DIGITS, then A ← A*10 + d, shadow ← {shadow[4*DIGITS−5:0], d}. Count increments unless A was 0 and d = 0 (leading zero). At count = DIGITS the digit is ignored.
  - Display shows the A shadow.
  - Op 00–10: latch op, clear B/count → ENTER_B.
  - Eq: no effect.
- **ENTER_B**
  - Digit entry works as for A; display shows the B shadow.
  - Op 00–10 with B count = 0: replaces the pending op.
  - Op 00–10 with B count > 0: ignored.
  - Eq → CALC (B = 0 if no digits were entered).
- **CALC** (1 cycle)
  - res ← A+B, A−B (A<B flags negative), or A*B, full 2*BIN_W width.
  - If negative or res > 10^DIGITS − 1 → ERR.
  - Otherwise → CONV.
- **CONV** (BIN_W cycles)
  - Double-dabble: each cycle, add 3 to every BCD nibble ≥ 5, then shift left one bit with the next binary MSB.
  - After the BIN_W-th shift: data_out_bcd ← converted word, A ← res[BIN_W−1:0], A shadow ← converted word → SHOW.
- **SHOW**
  - Digit: start a new A (count reset, A = d) → ENTER_A.
  - Op 00–10: chain; result is A, latch op → ENTER_B.
  - Eq: ignored.
- **ERR**
  - data_out_bcd = {DIGITS{4'hE}}, err = 1.
  - Only clear or rst exits; digits and eq are ignored.
- **Clear (op 11):** accepted in any non-busy state. Zeroes A, B, counts, op and display; clears err → ENTER_A.
- **While busy (CALC, CONV):** all strobes are discarded and data_out_bcd holds the B shadow.

## Timing
- **Reset values:** data_out_bcd = 0, busy = 0, err = 0, state ENTER_A; all registers zero.
- **rst mid-CALC/CONV:** aborts the computation; reset values next cycle.
- **Digit/op/clear:** data_out_bcd is updated on the same edge that samples the strobe (1-cycle latency).
- **Eq sampled at edge E0:**
  - busy = 1 after E0.
  - At E0+1, CALC completes. On error: err = 1, display = E pattern, busy = 0 after E0+1.
  - Otherwise CONV runs for edges E0+2..E0+BIN_W+1. The result appears on data_out_bcd and busy falls after edge E0+BIN_W+1; for default parameters that is 15 edges after E0.
- **Strobe on the edge busy falls:** not accepted; the first accepted edge is the next one.
- **Multiply:** completes in the single CALC cycle. The full 2*BIN_W-bit product is compared against 10^DIGITS − 1.

## Test plan
Defaults DIGITS=4, BIN_W=14 unless noted.
- **Operand entry:** rst, then digits 1,2,3,4,5 → display 0x0001, 0x0012, 0x0123, 0x1234, 0x1234 (fifth ignored); leading 0,0,7 → 0x0007.
- **Add with latency and chaining:**
  - 12 + 34 = → busy high for exactly 15 cycles, then display 0x0046, err = 0.
  - Then + 1 = → 0x0047.
- **Error paths and clear:**
  - 5 − 7 = → err = 1, display 0xEEEE.
  - 9999 × 2 = → err = 1.
  - Digit in ERR → no change.
  - Clear → 0x0000, err = 0.
- **Boundary:** 99 × 101 = → 0x9999, no error; 5000 + 4999 = → 0x9999; 5000 + 5000 = → err.
- **Simultaneous and busy:**
  - is_num (3) with is_op in the same cycle → digit taken, op dropped.
  - Strobes during busy → discarded; the result is unchanged.
  - Op pressed twice in ENTER_B with no digits → the last op is used.
- **Reset mid-CONV:** rst 5 cycles after eq → next cycle display 0, busy 0, err 0; a following 2 + 2 = gives 0x0004.

Source files
------------

// File: rtl/calc_core.sv
// Keypad-driven calculator core: operand entry, add/sub/mul, result chaining,
// error state and a sequential double-dabble binary-to-BCD converter.
module calc_core #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            num_val,
    input  logic [1:0]            op_val,
    input  logic                  is_num,
    input  logic                  is_op,
    input  logic                  is_eq,
    output logic [4*DIGITS-1:0]   data_out_bcd,
    output logic                  busy,
    output logic                  err
);
    localparam int unsigned DW   = 4 * DIGITS;
    localparam int unsigned RW   = 2 * BIN_W;
    localparam int unsigned CW   = $clog2(DIGITS + 1);
    localparam int unsigned BC_W = $clog2(BIN_W);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DIGITS);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(BIN_W - 1);
    localparam logic [RW-1:0]   RES_MAX  = RW'(10 ** DIGITS - 1);

    typedef enum logic [2:0] {
        S_ENTER_A, S_ENTER_B, S_CALC, S_CONV, S_SHOW, S_ERR
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [BIN_W-1:0]  r_a, r_b, r_res, r_bin;
    logic [DW-1:0]     r_sha, r_shb, r_bcd;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_op;
    logic [BC_W-1:0]   r_bit;

    logic              w_dig, w_op, w_eq, w_clr, w_arith, w_busy, w_take_dig, w_cnt_inc;
    logic [BIN_W-1:0]  w_opnd, w_opnd_nxt;
    logic [DW-1:0]     w_sh, w_sh_nxt, w_adj, w_dd;
    logic [RW-1:0]     w_a_ext, w_b_ext, w_res;
    logic              w_neg, w_calc_err;

    // Strobe priority: a digit strobe masks op and eq, an op strobe masks eq.
    always_comb begin
        w_dig   = is_num && (num_val <= 4'd9);
        w_op    = !is_num && is_op;
        w_eq    = !is_num && !is_op && is_eq;
        w_clr   = w_op && (op_val == 2'b11);
        w_arith = w_op && (op_val != 2'b11);
        w_busy  = (r_state == S_CALC) || (r_state == S_CONV);
    end

    always_comb begin
        w_opnd     = (r_state == S_ENTER_B) ? r_b : r_a;
        w_sh       = (r_state == S_ENTER_B) ? r_shb : r_sha;
        w_opnd_nxt = w_opnd * BIN_W'(10) + BIN_W'(num_val);
        w_sh_nxt   = {w_sh[DW-5:0], num_val};
        w_cnt_inc  = !((w_opnd == '0) && (num_val == 4'd0));
        w_take_dig = w_dig && (r_cnt < CNT_FULL);
    end

    always_comb begin
        w_a_ext = RW'(r_a);
        w_b_ext = RW'(r_b);
        w_res   = '0;
        w_neg   = 1'b0;
        case (r_op)
            2'b00:   w_res = w_a_ext + w_b_ext;
            2'b01: begin
                w_res = w_a_ext - w_b_ext;
                w_neg = (r_a < r_b);
            end
            2'b10:   w_res = w_a_ext * w_b_ext;
            default: w_res = '0;
        endcase
        w_calc_err = w_neg || (w_res > RES_MAX);
    end

    // One double-dabble step: add-3 correction, then shift in the next binary MSB.
    always_comb begin
        w_adj = r_bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        w_dd = DW'({w_adj, r_bin[BIN_W-1]});
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ENTER_A: if (w_clr) w_state_nxt = S_ENTER_A;
                       else if (w_arith) w_state_nxt = S_ENTER_B;
            S_ENTER_B: if (w_clr) w_state_nxt = S_ENTER_A;
                       else if (w_eq) w_state_nxt = S_CALC;
            S_CALC:    w_state_nxt = w_calc_err ? S_ERR : S_CONV;
            S_CONV:    if (r_bit == BIT_LAST) w_state_nxt = S_SHOW;
            S_SHOW:    if (w_dig || w_clr) w_state_nxt = S_ENTER_A;
                       else if (w_arith) w_state_nxt = S_ENTER_B;
            S_ERR:     if (w_clr) w_state_nxt = S_ENTER_A;
            default:   w_state_nxt = S_ENTER_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_ENTER_A;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0; r_b <= '0; r_res <= '0; r_bin <= '0;
            r_sha <= '0; r_shb <= '0; r_bcd <= '0;
            r_cnt <= '0; r_op <= '0; r_bit <= '0;
        end else if (w_clr && !w_busy) begin
            r_a <= '0; r_b <= '0; r_sha <= '0; r_shb <= '0;
            r_cnt <= '0; r_op <= '0;
        end else begin
            case (r_state)
                S_ENTER_A, S_ENTER_B: begin
                    if (w_take_dig) begin
                        if (r_state == S_ENTER_B) begin
                            r_b <= w_opnd_nxt; r_shb <= w_sh_nxt;
                        end else begin
                            r_a <= w_opnd_nxt; r_sha <= w_sh_nxt;
                        end
                        if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_arith && r_state == S_ENTER_A) begin
                        r_op <= op_val; r_b <= '0; r_shb <= '0; r_cnt <= '0;
                    end
                    if (w_arith && r_state == S_ENTER_B && r_cnt == '0)
                        r_op <= op_val;
                end
                S_CALC: begin
                    r_res <= w_res[BIN_W-1:0];
                    r_bin <= w_res[BIN_W-1:0];
                    r_bcd <= '0;
                    r_bit <= '0;
                end
                S_CONV: begin
                    r_bcd <= w_dd;
                    r_bin <= r_bin << 1;
                    r_bit <= r_bit + BC_W'(1);
                    if (r_bit == BIT_LAST) begin
                        r_a   <= r_res;
                        r_sha <= w_dd;
                    end
                end
                S_SHOW: begin
                    if (w_dig) begin
                        r_a   <= BIN_W'(num_val);
                        r_sha <= DW'(num_val);
                        r_cnt <= (num_val != 4'd0) ? CW'(1) : '0;
                    end else if (w_arith) begin
                        r_op <= op_val; r_b <= '0; r_shb <= '0; r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            S_ENTER_A, S_SHOW:           data_out_bcd = r_sha;
            S_ENTER_B, S_CALC, S_CONV:   data_out_bcd = r_shb;
            S_ERR:                       data_out_bcd = {DIGITS{4'hE}};
            default:                     data_out_bcd = '0;
        endcase
        busy = w_busy;
        err  = (r_state == S_ERR);
    end
endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core: entry, arithmetic, latency, errors, busy masking, reset abort.
module tb_calc_core;
    logic        clk, rst;
    logic [3:0]  num_val;
    logic [1:0]  op_val;
    logic        is_num, is_op, is_eq;
    logic [15:0] data_out_bcd;
    logic        busy, err;
    int          checks, failures, n;

    calc_core #(.DIGITS(4), .BIN_W(14)) dut (
        .clk(clk), .rst(rst), .num_val(num_val), .op_val(op_val),
        .is_num(is_num), .is_op(is_op), .is_eq(is_eq),
        .data_out_bcd(data_out_bcd), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // All drivers are called at a negedge and return at the following negedge.
    task automatic key(input logic [3:0] d);
        is_num = 1'b1; num_val = d;
        @(negedge clk);
        is_num = 1'b0;
    endtask

    task automatic op(input logic [1:0] o);
        is_op = 1'b1; op_val = o;
        @(negedge clk);
        is_op = 1'b0;
    endtask

    task automatic eq_wait(output int cyc);
        is_eq = 1'b1;
        @(negedge clk);
        is_eq = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; is_num = 0; is_op = 0; is_eq = 0; num_val = 0; op_val = 0;
        repeat (2) @(negedge clk);
        check("reset_dout", data_out_bcd, 16'h0000);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Operand entry and digit-count limit
        key(1); check("entry1", data_out_bcd, 16'h0001);
        key(2); check("entry2", data_out_bcd, 16'h0012);
        key(3); check("entry3", data_out_bcd, 16'h0123);
        key(4); check("entry4", data_out_bcd, 16'h1234);
        key(5); check("entry5_ignored", data_out_bcd, 16'h1234);
        op(2'b11); check("clear1", data_out_bcd, 16'h0000);
        key(0); key(0); check("lead_zero", data_out_bcd, 16'h0000);
        key(7); check("lead_7", data_out_bcd, 16'h0007);
        key(8); check("lead_78", data_out_bcd, 16'h0078);
        op(2'b11);

        // 12 + 34 with latency, then chain + 1
        key(1); key(2); op(2'b00);
        check("enter_b_blank", data_out_bcd, 16'h0000);
        key(3); key(4); check("b_34", data_out_bcd, 16'h0034);
        eq_wait(n);
        check("add_busy_cycles", n, 15);
        check("add_result", data_out_bcd, 16'h0046);
        check("add_err", err, 0);
        op(2'b00); key(1); eq_wait(n);
        check("chain_result", data_out_bcd, 16'h0047);

        // Error paths
        op(2'b11);
        key(5); op(2'b01); key(7); eq_wait(n);
        check("sub_err_cycles", n, 1);
        check("sub_err", err, 1);
        check("sub_err_busy", busy, 0);
        check("sub_err_dout", data_out_bcd, 16'hEEEE);
        key(3); check("err_digit_ignored", data_out_bcd, 16'hEEEE);
        is_eq = 1'b1; @(negedge clk); is_eq = 1'b0;
        check("err_eq_ignored", err, 1);
        op(2'b00); check("err_op_ignored", err, 1);
        op(2'b11);
        check("err_clear_dout", data_out_bcd, 16'h0000);
        check("err_clear_err", err, 0);
        key(9); key(9); key(9); key(9); op(2'b10); key(2); eq_wait(n);
        check("mul_overflow_err", err, 1);
        op(2'b11);

        // Boundaries
        key(9); key(9); op(2'b10); key(1); key(0); key(1);
        check("b_0101", data_out_bcd, 16'h0101);
        eq_wait(n);
        check("mul_9999", data_out_bcd, 16'h9999);
        check("mul_9999_err", err, 0);
        op(2'b11);
        key(5); key(0); key(0); key(0); op(2'b00); key(4); key(9); key(9); key(9); eq_wait(n);
        check("add_9999", data_out_bcd, 16'h9999);
        op(2'b11);
        key(5); key(0); key(0); key(0); op(2'b00); key(5); key(0); key(0); key(0); eq_wait(n);
        check("add_10000_err", err, 1);
        op(2'b11);

        // Simultaneous strobes: digit wins, op dropped
        is_num = 1'b1; num_val = 4'd3; is_op = 1'b1; op_val = 2'b00;
        @(negedge clk);
        is_num = 1'b0; is_op = 1'b0;
        check("simul_digit", data_out_bcd, 16'h0003);
        key(4); check("simul_still_a", data_out_bcd, 16'h0034);

        // Strobes during busy, including on the edge busy falls
        op(2'b00); key(6);
        is_eq = 1'b1; @(negedge clk); is_eq = 1'b0;
        check("busy_high", busy, 1);
        check("busy_shows_b", data_out_bcd, 16'h0006);
        for (int k = 0; k < 15; k++) begin
            is_num = 0; is_op = 0; is_eq = 0;
            case ((k + 1) % 3)
                0: begin is_num = 1'b1; num_val = 4'd9; end
                1: begin is_op = 1'b1; op_val = 2'b11; end
                default: is_eq = 1'b1;
            endcase
            @(negedge clk);
        end
        is_num = 0; is_op = 0; is_eq = 0;
        check("busy_done", busy, 0);
        check("busy_masked_result", data_out_bcd, 16'h0040);
        check("busy_masked_err", err, 0);
        key(5); check("show_new_a", data_out_bcd, 16'h0005);
        op(2'b11);

        // Op replaced in ENTER_B with no digits; op after digits ignored
        key(8); op(2'b01); op(2'b10); key(3); op(2'b00);
        check("op_after_digit", data_out_bcd, 16'h0003);
        eq_wait(n);
        check("last_op_used", data_out_bcd, 16'h0024);
        op(2'b11);

        // Reset mid-conversion
        key(1); op(2'b00); key(1);
        is_eq = 1'b1; @(negedge clk); is_eq = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_conv_busy", busy, 1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("abort_dout", data_out_bcd, 16'h0000);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        key(2); op(2'b00); key(2); eq_wait(n);
        check("post_reset_add", data_out_bcd, 16'h0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
